ha_serial_add_ctrl: RTL and testbench

- Sequencer that time-shares one external half-adder cell (sum = x XOR y, carry = x AND y) to perform a WIDTH-bit ripple addition.
- Each bit takes two passes through the shared cell, which together form a full adder. LSB is processed first.
- Sits between the top-level pin wrapper and the half-adder datapath. Provides a start/busy/done handshake and holds the registered result.

---
 rtl/ha_serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_ha_serial_add_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_add_ctrl.sv
// Sequencer that time-shares one external half-adder to perform a WIDTH-bit
// ripple addition, two passes per bit (a^b first, then with incoming carry).
module ha_serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ha_x,
  output logic             ha_y,
  input  logic             ha_s,
  input  logic             ha_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             s1_q;
  logic             c1_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_d;

  // First and second pass carries are mutually exclusive, so OR acts as XOR.
  assign carry_d = c1_q | ha_c;

  // Operands are pure data: captured only on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (ena && (state_q == IDLE) && start) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_comb begin
    ha_x = 1'b0;
    ha_y = 1'b0;
    case (state_q)
      P0: begin
        ha_x = a_q[idx_q];
        ha_y = b_q[idx_q];
      end
      P1: begin
        ha_x = s1_q;
        ha_y = carry_q;
      end
      default: begin
        ha_x = 1'b0;
        ha_y = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s1_q    <= 1'b0;
      c1_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= P0;
          end
        end
        P0: begin
          s1_q    <= ha_s;
          c1_q    <= ha_c;
          state_q <= P1;
        end
        P1: begin
          sum_q[idx_q] <= ha_s;
          carry_q      <= carry_d;
          if (idx_q == IDX_LAST) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= P0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Directed bench for ha_serial_add_ctrl (WIDTH=4) with an ideal half-adder model.
module tb_ha_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       ha_x;
  logic       ha_y;
  logic       ha_s;
  logic       ha_c;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       cout;

  int compared = 0;
  int mism     = 0;

  ha_serial_add_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .a     (a),
    .b     (b),
    .ha_x  (ha_x),
    .ha_y  (ha_y),
    .ha_s  (ha_s),
    .ha_c  (ha_c),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  assign ha_s = ha_x ^ ha_y;
  assign ha_c = ha_x & ha_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation with a cycle-by-cycle check of the shared-cell inputs.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] es, input logic ec);
    logic c;
    c = 1'b0;
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    for (int i = 0; i < 4; i++) begin
      chk1("p0_busy", busy, 1'b1);
      chk1("p0_done", done, 1'b0);
      chk1("p0_hax", ha_x, av[i]);
      chk1("p0_hay", ha_y, bv[i]);
      step();
      chk1("p1_busy", busy, 1'b1);
      chk1("p1_hax", ha_x, av[i] ^ bv[i]);
      chk1("p1_hay", ha_y, c);
      c = (av[i] & bv[i]) | ((av[i] ^ bv[i]) & c);
      step();
    end
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chk1("done_hax", ha_x, 1'b0);
    chk4("sum", sum, es);
    chk1("cout", cout, ec);
    step();
    chk1("done_drop", done, 1'b0);
    chk4("sum_hold", sum, es);
    chk1("cout_hold", cout, ec);
  endtask

  initial begin
    logic [4:0] ref_r;
    logic [3:0] ra;
    logic [3:0] rb;
    int         cnt;
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk4("rst_sum", sum, 4'd0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_hax", ha_x, 1'b0);
    chk1("rst_hay", ha_y, 1'b0);
    rst_n = 1'b1;
    step();
    chk1("idle_busy", busy, 1'b0);

    do_op(4'd5, 4'd3, 4'd8, 1'b0);
    do_op(4'd15, 4'd1, 4'd0, 1'b1);
    do_op(4'd15, 4'd15, 4'd14, 1'b1);
    do_op(4'd0, 4'd0, 4'd0, 1'b0);

    // start held for 30 cycles; operands scrambled except at acceptance edges
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k % 10 == 0) begin
        a = 4'd9;
        b = 4'd9;
      end else begin
        a = 4'(k);
        b = ~4'(k);
      end
      step();
      chk1("held_done", done, (k % 10 == 8));
      if (k % 10 == 8) begin
        chk4("held_sum", sum, 4'd2);
        chk1("held_cout", cout, 1'b1);
      end
    end
    start = 1'b0;
    step();
    chk1("held_idle", busy, 1'b0);

    // ena low for 3 cycles during P1 of bit 2: 11+6 = 17
    a = 4'd11;
    b = 4'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1("frz_hax", ha_x, 1'b1);
      chk1("frz_hay", ha_y, 1'b1);
      chk1("frz_busy", busy, 1'b1);
      step();
    end
    chk1("frz_hax_end", ha_x, 1'b1);
    ena = 1'b1;
    step();
    chk1("ena_nodone1", done, 1'b0);
    step();
    chk1("ena_nodone2", done, 1'b0);
    step();
    chk1("ena_done", done, 1'b1);
    chk4("ena_sum", sum, 4'd1);
    chk1("ena_cout", cout, 1'b1);
    step();

    // reset mid-operation while in P0 of bit 1
    a = 4'd5;
    b = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk1("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk4("arst_sum", sum, 4'd0);
    chk1("arst_cout", cout, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_hax", ha_x, 1'b0);
    chk1("arst_hay", ha_y, 1'b0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk1("post_rst_nodone", done, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
    end
    do_op(4'd6, 4'd7, 4'd13, 1'b0);

    // random operands against a+b
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ref_r = {1'b0, ra} + {1'b0, rb};
      do_op(ra, rb, ref_r[3:0], ref_r[4]);
      cnt++;
    end
    chk4("rand_ops", 4'(cnt % 16), 4'(200 % 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
